instr_queue: RTL and testbench

Instruction queue between the fetch stage and the decode/immediate-extension stage of the RISC-V core. It buffers fetched instructions with their PC in a small FIFO. On enqueue it pre-decodes the 7-bit opcode into the 3-bit immediate-source select consumed by the immediate extender, so decode sees a registered `immsrc` and does not have to derive it. Fetch and decode sides each use a valid/ready handshake, and a synchronous flush discards all queued entries on redirect.

---
 rtl/instr_queue.sv | 110 +++++++++++
 tb/tb_instr_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO. The immediate-source select and the illegal-opcode
// flag are pre-decoded when an entry is pushed, so decode reads them registered.

module instr_predecode (
   input  logic [6:0] opcode,
   output logic [2:0] immsrc,
   output logic       illegal
);
   always_comb begin
      immsrc  = 3'b000;
      illegal = 1'b0;
      case (opcode)
         7'b0000011, 7'b0010011, 7'b1100111,
         7'b0110011, 7'b1110011, 7'b0001111: immsrc = 3'b000;
         7'b0100011:                         immsrc = 3'b001;
         7'b1100011:                         immsrc = 3'b010;
         7'b1101111:                         immsrc = 3'b011;
         7'b0110111, 7'b0010111:             immsrc = 3'b100;
         default: begin
            immsrc  = 3'b111;
            illegal = 1'b1;
         end
      endcase
   end
endmodule

module instr_queue #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     f_valid,
   output logic                     f_ready,
   input  logic [31:0]              f_instr,
   input  logic [31:0]              f_pc,
   input  logic                     flush,
   output logic                     d_valid,
   input  logic                     d_ready,
   output logic [31:0]              d_instr,
   output logic [31:0]              d_pc,
   output logic [2:0]               d_immsrc,
   output logic                     d_illegal,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  immsrc;
      logic        illegal;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          wr_entry;
   entry_t          rd_entry;
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   cnt;
   logic            push, pop;
   logic [2:0]      pd_immsrc;
   logic            pd_illegal;

   instr_predecode u_pd (
      .opcode  (f_instr[6:0]),
      .immsrc  (pd_immsrc),
      .illegal (pd_illegal)
   );

   // full queue refuses a push even if it pops this cycle
   assign f_ready = (cnt != FULL);
   assign d_valid = (cnt != '0);
   assign push    = f_valid && f_ready;
   assign pop     = d_valid && d_ready;

   assign wr_entry = '{instr: f_instr, pc: f_pc, immsrc: pd_immsrc, illegal: pd_illegal};
   assign rd_entry = mem[rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= wr_entry;
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign d_instr   = rd_entry.instr;
   assign d_pc      = rd_entry.pc;
   assign d_immsrc  = rd_entry.immsrc;
   assign d_illegal = rd_entry.illegal;
   assign count     = cnt;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: expected entries queued on accepted pushes,
// compared against the head on every accepted pop.

module tb_instr_queue;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        f_valid = 1'b0;
   logic        f_ready;
   logic [31:0] f_instr = '0;
   logic [31:0] f_pc = '0;
   logic        flush = 1'b0;
   logic        d_valid;
   logic        d_ready = 1'b0;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic [2:0]  d_immsrc;
   logic        d_illegal;
   logic [$clog2(DEPTH):0] count;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  immsrc;
      logic        illegal;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   logic [31:0] pc_ctr = 32'h0;

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .f_valid(f_valid), .f_ready(f_ready),
      .f_instr(f_instr), .f_pc(f_pc), .flush(flush), .d_valid(d_valid),
      .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc), .d_immsrc(d_immsrc),
      .d_illegal(d_illegal), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e.instr = instr; e.pc = pc; e.illegal = 1'b0;
      case (instr[6:0])
         7'h03, 7'h13, 7'h67, 7'h33, 7'h73, 7'h0f: e.immsrc = 3'd0;
         7'h23: e.immsrc = 3'd1;
         7'h63: e.immsrc = 3'd2;
         7'h6f: e.immsrc = 3'd3;
         7'h37, 7'h17: e.immsrc = 3'd4;
         default: begin e.immsrc = 3'd7; e.illegal = 1'b1; end
      endcase
      return e;
   endfunction

   // model occupancy decides acceptance; DUT outputs are only compared
   always @(negedge clk) begin
      if (reset && mon_en) begin
         automatic int  sz = q.size();
         automatic bit  do_pop = (sz != 0) && d_ready;
         automatic bit  do_push = (sz != DEPTH) && f_valid;
         chk("count", 64'(count), 64'(sz));
         chk("f_ready", 64'(f_ready), 64'(sz != DEPTH));
         chk("d_valid", 64'(d_valid), 64'(sz != 0));
         if (flush) q.delete();
         else begin
            if (do_pop) begin
               automatic exp_t e = q.pop_front();
               chk("d_instr", 64'(d_instr), 64'(e.instr));
               chk("d_pc", 64'(d_pc), 64'(e.pc));
               chk("d_immsrc", 64'(d_immsrc), 64'(e.immsrc));
               chk("d_illegal", 64'(d_illegal), 64'(e.illegal));
            end
            if (do_push) q.push_back(mk(f_instr, f_pc));
         end
      end
   end

   task automatic cyc(input bit fv, input logic [31:0] ins, input bit dr, input bit fl);
      f_valid = fv; f_instr = ins; f_pc = pc_ctr; d_ready = dr; flush = fl;
      @(posedge clk); #1;
      if (fv) pc_ctr += 32'd4;
      f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
   endtask

   logic [6:0] ops [16] = '{7'h03, 7'h13, 7'h67, 7'h33, 7'h73, 7'h0f, 7'h23, 7'h63,
                            7'h6f, 7'h37, 7'h17, 7'h7f, 7'h00, 7'h5b, 7'h23, 7'h63};

   initial begin
      logic [31:0] rnd;
      // reset state
      #12;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_f_ready", 64'(f_ready), 64'd1);
      chk("rst_d_valid", 64'(d_valid), 64'd0);
      chk("rst_d_instr", 64'(d_instr), 64'd0);
      chk("rst_d_pc", 64'(d_pc), 64'd0);
      chk("rst_d_immsrc", 64'(d_immsrc), 64'd0);
      chk("rst_d_illegal", 64'(d_illegal), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      mon_en = 1'b1;

      // addi, one-cycle latency
      cyc(1, 32'h00500093, 0, 0);
      chk("addi_d_valid", 64'(d_valid), 64'd1);
      chk("addi_d_instr", 64'(d_instr), 64'h00500093);
      chk("addi_d_immsrc", 64'(d_immsrc), 64'd0);
      chk("addi_d_illegal", 64'(d_illegal), 64'd0);
      chk("addi_count", 64'(count), 64'd1);
      cyc(0, 0, 1, 0);

      // back-pressure: sw, beq fill; jal held at fetch
      cyc(1, 32'h00112023, 0, 0);
      cyc(1, 32'h00208463, 0, 0);
      chk("full_f_ready", 64'(f_ready), 64'd0);
      chk("full_count", 64'(count), 64'd2);
      cyc(1, 32'h008000EF, 0, 0);
      chk("held_head", 64'(d_instr), 64'h00112023);
      pc_ctr -= 32'd4;
      cyc(1, 32'h008000EF, 1, 0);
      cyc(1, 32'h008000EF, 1, 0);
      chk("jal_head", 64'(d_immsrc), 64'd3);
      cyc(0, 0, 1, 0);

      // streaming with wrap
      cyc(1, 32'h00000013, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, (i == 4) ? 32'h123450B7 : 32'h00100093 + 32'(i << 20), 1, 0);
         chk("stream_count", 64'(count), 64'd1);
         if (i == 4) chk("lui_immsrc", 64'(d_immsrc), 64'd4);
      end
      cyc(0, 0, 1, 0);

      // flush while full with a push offered
      cyc(1, 32'h00000033, 0, 0);
      cyc(1, 32'h00000073, 0, 0);
      cyc(1, 32'h0BADC0B3, 1, 1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_d_valid", 64'(d_valid), 64'd0);
      chk("flush_f_ready", 64'(f_ready), 64'd1);
      cyc(1, 32'h0000000F, 0, 0);
      cyc(0, 0, 1, 0);

      // illegal opcode
      cyc(1, 32'hFFFFFFFF, 0, 0);
      chk("ill_d_illegal", 64'(d_illegal), 64'd1);
      chk("ill_d_immsrc", 64'(d_immsrc), 64'd7);
      cyc(0, 0, 1, 0);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         rnd = $urandom();
         cyc(rnd[0] | rnd[1], {rnd[31:7], ops[rnd[11:8]]}, rnd[2] | rnd[3], rnd[7:4] == 4'hF);
      end
      while (q.size() != 0 && checks < 100000) cyc(0, 0, 1, 0);

      // asynchronous reset mid-cycle with a full queue
      cyc(1, 32'h00500093, 0, 0);
      cyc(1, 32'h00112023, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_d_valid", 64'(d_valid), 64'd0);
      chk("arst_d_instr", 64'(d_instr), 64'd0);
      chk("arst_d_pc", 64'(d_pc), 64'd0);
      q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      cyc(0, 0, 1, 0);
      cyc(1, 32'h00208463, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
